// File: rtl/tdc_code_accumulator_pkg.sv
// Shared types and width constants for the TDC code accumulator.
// Default widths live here so the decoder, interface and top stay consistent.
package tdc_acc_pkg;

  localparam int CODE_W_DEF   = 8;
  localparam int MAX_LOG2_DEF = 8;
  localparam int CNT_W        = $clog2(CODE_W_DEF + 1);
  localparam int SUM_W        = CNT_W + MAX_LOG2_DEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Requested window exponents beyond the supported maximum are clamped.
  function automatic logic [3:0] clamp_log2(input logic [3:0] w, input int max_log2);
    logic [3:0] lim;
    lim = 4'(max_log2);
    if (w > lim) begin
      return lim;
    end else begin
      return w;
    end
  endfunction

endpackage

// File: rtl/tdc_code_accumulator_if.sv
// Sample/control/result bundle between the TDC stage, this accumulator and the readout mux.
interface tdc_code_accumulator_if
  import tdc_acc_pkg::*;
#(
  parameter int CODE_W   = CODE_W_DEF,
  parameter int MAX_LOG2 = MAX_LOG2_DEF
);
  localparam int TAP_W = $clog2(CODE_W + 1);
  localparam int ACC_W = TAP_W + MAX_LOG2;

  logic [CODE_W-1:0] code_i;
  logic              code_valid_i;
  logic              start_i;
  logic [3:0]        win_log2_i;
  logic              busy_o;
  logic              done_o;
  logic [ACC_W-1:0]  sum_o;
  logic [TAP_W-1:0]  mean_o;
  logic [TAP_W-1:0]  min_o;
  logic [TAP_W-1:0]  max_o;
  logic [7:0]        bubble_cnt_o;

  modport master (
    output code_i, code_valid_i, start_i, win_log2_i,
    input  busy_o, done_o, sum_o, mean_o, min_o, max_o, bubble_cnt_o
  );

  modport slave (
    input  code_i, code_valid_i, start_i, win_log2_i,
    output busy_o, done_o, sum_o, mean_o, min_o, max_o, bubble_cnt_o
  );

endinterface

// File: rtl/tdc_code_accumulator_chk.sv
// Protocol and result-consistency assertions for the accumulator outputs.
module tdc_code_accumulator_chk #(
  parameter int TAP_W = 4
) (
  input logic             clk,
  input logic             rst,
  input logic             busy,
  input logic             done,
  input logic [TAP_W-1:0] mean,
  input logic [TAP_W-1:0] min_v,
  input logic [TAP_W-1:0] max_v,
  input logic [7:0]       bubble_cnt
);

  a_done_not_busy: assert property (@(posedge clk) disable iff (rst) done |-> !busy);

  a_done_pulse: assert property (@(posedge clk) disable iff (rst) done |=> !done);

  // A truncated mean of integers always lies between the window extremes.
  a_mean_range: assert property (@(posedge clk) disable iff (rst)
    done |-> ((mean >= min_v) && (mean <= max_v)));

  a_bubble_mono: assert property (@(posedge clk) disable iff (rst)
    (busy && $past(busy)) |-> (bubble_cnt >= $past(bubble_cnt)));

endmodule

// File: rtl/tdc_thermo_decode.sv
// Combinational thermometer decoder: tap count plus bubble flag.
// Kept standalone so live-code display logic can reuse it.
module tdc_thermo_decode #(
  parameter int CODE_W = 8,
  parameter int TAP_W  = $clog2(CODE_W + 1)
) (
  input  logic [CODE_W-1:0] code,
  output logic [TAP_W-1:0]  count,
  output logic              bubble
);

  logic [TAP_W-1:0] count_s;
  logic [CODE_W-1:0] plus_one_s;

  // Population count of the code and detection of non 0..01..1 patterns.
  always_comb begin
    count_s    = '0;
    plus_one_s = code + CODE_W'(1);
    for (int i = 0; i < CODE_W; i++) begin
      count_s = count_s + TAP_W'(code[i]);
    end
  end

  assign count  = count_s;
  assign bubble = ((code & plus_one_s) != '0);

endmodule

// File: rtl/tdc_code_accumulator.sv
// Windowed statistics (sum, mean, min, max, bubble count) over TDC thermometer samples.
// Results are held between windows so slow readout can sample them at leisure.
module tdc_code_accumulator
  import tdc_acc_pkg::*;
#(
  parameter int CODE_W   = CODE_W_DEF,
  parameter int MAX_LOG2 = MAX_LOG2_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  tdc_code_accumulator_if.slave bus
);

  localparam int TAP_W  = $clog2(CODE_W + 1);
  localparam int ACC_W  = TAP_W + MAX_LOG2;
  localparam int WCNT_W = MAX_LOG2 + 1;
  localparam int BUB_W  = 8;

  state_e            state_r, state_next_s;
  logic [3:0]        win_r;
  logic [WCNT_W-1:0] cnt_r, cnt_next_s, target_s;
  logic [ACC_W-1:0]  sum_acc_r, sum_next_s, sum_r;
  logic [TAP_W-1:0]  min_acc_r, max_acc_r, min_next_s, max_next_s, mean_next_s;
  logic [TAP_W-1:0]  mean_r, min_r, max_r;
  logic [BUB_W-1:0]  bub_r, bub_next_s;
  logic              busy_r, done_r;
  logic [TAP_W-1:0]  count_s;
  logic              bubble_s;
  logic              start_s, accept_s, last_s;

  tdc_thermo_decode #(
    .CODE_W (CODE_W),
    .TAP_W  (TAP_W)
  ) u_decode (
    .code   (bus.code_i),
    .count  (count_s),
    .bubble (bubble_s)
  );

  // Next values of the running statistics if the current sample is accepted.
  always_comb begin
    target_s    = WCNT_W'(1) << win_r;
    cnt_next_s  = cnt_r + WCNT_W'(1);
    sum_next_s  = sum_acc_r + ACC_W'(count_s);
    mean_next_s = TAP_W'(sum_next_s >> win_r);
    if (count_s < min_acc_r) begin
      min_next_s = count_s;
    end else begin
      min_next_s = min_acc_r;
    end
    if (count_s > max_acc_r) begin
      max_next_s = count_s;
    end else begin
      max_next_s = max_acc_r;
    end
    if (bubble_s && (bub_r != {BUB_W{1'b1}})) begin
      bub_next_s = bub_r + BUB_W'(1);
    end else begin
      bub_next_s = bub_r;
    end
  end

  // FSM next-state and per-cycle control strobes.
  always_comb begin
    state_next_s = state_r;
    start_s      = 1'b0;
    accept_s     = 1'b0;
    last_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start_i) begin
          start_s      = 1'b1;
          state_next_s = ST_ACC;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ACC: begin
        if (bus.code_valid_i) begin
          accept_s = 1'b1;
          if (cnt_next_s == target_s) begin
            last_s       = 1'b1;
            state_next_s = ST_DONE;
          end else begin
            state_next_s = ST_ACC;
          end
        end else begin
          state_next_s = ST_ACC;
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Running accumulators; a start re-arms them with min at full scale.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_r     <= 4'd0;
      cnt_r     <= '0;
      sum_acc_r <= '0;
      min_acc_r <= TAP_W'(CODE_W);
      max_acc_r <= '0;
      bub_r     <= '0;
    end else if (start_s) begin
      win_r     <= clamp_log2(bus.win_log2_i, MAX_LOG2);
      cnt_r     <= '0;
      sum_acc_r <= '0;
      min_acc_r <= TAP_W'(CODE_W);
      max_acc_r <= '0;
      bub_r     <= '0;
    end else if (accept_s) begin
      cnt_r     <= cnt_next_s;
      sum_acc_r <= sum_next_s;
      min_acc_r <= min_next_s;
      max_acc_r <= max_next_s;
      bub_r     <= bub_next_s;
    end
  end

  // Held result registers, loaded only by the sample that closes the window.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_r  <= '0;
      mean_r <= '0;
      min_r  <= '0;
      max_r  <= '0;
    end else if (last_s) begin
      sum_r  <= sum_next_s;
      mean_r <= mean_next_s;
      min_r  <= min_next_s;
      max_r  <= max_next_s;
    end
  end

  // Status flags registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_next_s == ST_ACC);
      done_r <= (state_next_s == ST_DONE);
    end
  end

  assign bus.busy_o       = busy_r;
  assign bus.done_o       = done_r;
  assign bus.sum_o        = sum_r;
  assign bus.mean_o       = mean_r;
  assign bus.min_o        = min_r;
  assign bus.max_o        = max_r;
  assign bus.bubble_cnt_o = bub_r;

  tdc_code_accumulator_chk #(
    .TAP_W (TAP_W)
  ) u_chk (
    .clk        (clk),
    .rst        (rst),
    .busy       (busy_r),
    .done       (done_r),
    .mean       (mean_r),
    .min_v      (min_r),
    .max_v      (max_r),
    .bubble_cnt (bub_r)
  );

endmodule

// File: tb/tb_tdc_code_accumulator.sv
// Randomised plus directed bench for tdc_code_accumulator; a monitor scores every done pulse
// against window statistics computed from the sample list.
module tb_tdc_code_accumulator;
  import tdc_acc_pkg::*;

  typedef struct {
    int sum;
    int mean;
    int mn;
    int mx;
    int bub;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tdc_code_accumulator_if bus ();

  tdc_code_accumulator dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         checks = 0;
  int         errors = 0;
  exp_t       exp_q[$];
  exp_t       hold_exp;
  bit         hold_valid = 1'b0;
  logic [7:0] codes_q[$];
  exp_t       mon_e;
  bit         prev_done = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_thermo(input logic [7:0] c);
    for (int k = 0; k <= 8; k++) begin
      if (int'(c) == ((1 << k) - 1)) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Statistics of the first n queued samples for a window of 2^w_eff.
  function automatic exp_t model(input int w_eff, input int n);
    exp_t e;
    e.sum = 0; e.mn = 8; e.mx = 0; e.bub = 0;
    for (int i = 0; i < n; i++) begin
      int c;
      c = $countones(codes_q[i]);
      e.sum += c;
      if (c < e.mn) e.mn = c;
      if (c > e.mx) e.mx = c;
      if (!is_thermo(codes_q[i]) && e.bub < 255) e.bub++;
    end
    e.mean = e.sum / (1 << w_eff);
    return e;
  endfunction

  // Scoreboard monitor: every done pulse must match the oldest pending window.
  always @(negedge clk) begin
    if (!rst && bus.done_o) begin
      chk("done_width", int'(prev_done), 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0 at %0t", $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sum",        int'(bus.sum_o),        mon_e.sum);
        chk("mean",       int'(bus.mean_o),       mon_e.mean);
        chk("min",        int'(bus.min_o),        mon_e.mn);
        chk("max",        int'(bus.max_o),        mon_e.mx);
        chk("bubble_cnt", int'(bus.bubble_cnt_o), mon_e.bub);
      end
    end
    prev_done = bus.done_o;
  end

  task automatic run_window(input int w, input int gap, input bit extra_start);
    int   w_eff;
    int   n;
    exp_t e;
    exp_t part;
    w_eff = (w > 8) ? 8 : w;
    n     = codes_q.size();
    // A strobe coincident with start must not be counted.
    bus.win_log2_i   = 4'(w);
    bus.start_i      = 1'b1;
    bus.code_valid_i = 1'b1;
    bus.code_i       = 8'hFF;
    tick();
    bus.start_i      = 1'b0;
    bus.code_valid_i = 1'b0;
    chk("busy_after_start", int'(bus.busy_o), 1);
    chk("bubble_cleared", int'(bus.bubble_cnt_o), 0);
    e = model(w_eff, n);
    exp_q.push_back(e);
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          bus.start_i = extra_start && (g == 0);
          tick();
          bus.start_i = 1'b0;
        end
      end
      bus.code_i       = codes_q[i];
      bus.code_valid_i = 1'b1;
      tick();
      bus.code_valid_i = 1'b0;
      part = model(w_eff, i + 1);
      chk("bubble_live", int'(bus.bubble_cnt_o), part.bub);
      if (i < n - 1) begin
        chk("busy_mid", int'(bus.busy_o), 1);
        if (hold_valid) chk("hold_sum", int'(bus.sum_o), hold_exp.sum);
      end
    end
    chk("done_latency", int'(bus.done_o), 1);
    chk("busy_drop", int'(bus.busy_o), 0);
    tick();
    chk("done_clear", int'(bus.done_o), 0);
    chk("result_hold", int'(bus.sum_o), e.sum);
    hold_exp   = e;
    hold_valid = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    bus.code_i       = 8'h00;
    bus.code_valid_i = 1'b0;
    bus.start_i      = 1'b0;
    bus.win_log2_i   = 4'd0;
    rst              = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", int'(bus.busy_o), 0);
    chk("rst_done", int'(bus.done_o), 0);
    chk("rst_sum",  int'(bus.sum_o),  0);
    chk("rst_min",  int'(bus.min_o),  0);
    chk("rst_max",  int'(bus.max_o),  0);
    chk("rst_bub",  int'(bus.bubble_cnt_o), 0);

    codes_q = '{8'h0F, 8'h07, 8'h1F, 8'h0F};
    run_window(2, 0, 1'b0);

    codes_q = '{8'h0B};
    run_window(0, 0, 1'b0);

    codes_q = '{8'h01, 8'hFF};
    run_window(1, 5, 1'b1);

    codes_q.delete();
    for (int i = 0; i < 256; i++) codes_q.push_back(8'h0A);
    run_window(12, 0, 1'b0);

    // Abort a W=3 window after five samples with a reset.
    bus.win_log2_i = 4'd3;
    bus.start_i    = 1'b1;
    tick();
    bus.start_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.code_i       = 8'h3F;
      bus.code_valid_i = 1'b1;
      tick();
    end
    bus.code_valid_i = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", int'(bus.busy_o), 0);
    chk("abort_sum",  int'(bus.sum_o),  0);
    chk("abort_mean", int'(bus.mean_o), 0);
    chk("abort_max",  int'(bus.max_o),  0);
    chk("abort_bub",  int'(bus.bubble_cnt_o), 0);
    hold_exp = '{0, 0, 0, 0, 0};
    for (int i = 0; i < 6; i++) begin
      bus.code_valid_i = 1'b1;
      tick();
      chk("abort_no_done", int'(bus.done_o), 0);
    end
    bus.code_valid_i = 1'b0;

    codes_q = '{8'h03};
    run_window(0, 0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      int w;
      w = $urandom_range(0, 5);
      codes_q.delete();
      for (int i = 0; i < (1 << w); i++) begin
        if ($urandom_range(0, 1) == 0) begin
          int k;
          k = $urandom_range(0, 8);
          codes_q.push_back(8'((1 << k) - 1));
        end else begin
          codes_q.push_back(8'($urandom));
        end
      end
      run_window(w, $urandom_range(0, 2), $urandom_range(0, 1) == 1);
    end

    tick();
    tick();
    chk("pending_results", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
